// File: rtl/bsg_blackparrot_mem_channel_striper.sv
`default_nettype none
// ============================================================================
// Module   : bsg_blackparrot_mem_channel_striper
// Purpose  : Distributes BlackParrot memory commands across num_channels_p
//            DRAM-side channels. Each command goes to one channel, chosen by
//            region (top address bits) or striped (bits above the stripe
//            granule) interleaving. Responses are returned to the core in
//            command order by tracking channel IDs in an in-order FIFO.
// Ports    : clk_i, reset_n_i (sync, active-low)
//            mode_i / mode_o          - interleave mode request / latched mode
//            cmd_*                    - core command (ready/valid)
//            resp_*                   - core response (valid/yumi)
//            ch_cmd_*                 - per-channel commands (broadcast data)
//            ch_resp_*                - per-channel responses (valid/yumi)
//            outstanding_o            - commands awaiting a response
//            unexpected_resp_o        - sticky: response seen with none pending
// Revision : 1.0 - initial release
// ============================================================================
module bsg_blackparrot_mem_channel_striper #(
    parameter int num_channels_p    = 2,
    parameter int addr_width_p      = 40,
    parameter int msg_width_p       = 128,
    parameter int stripe_lg_p       = 6,
    parameter int max_outstanding_p = 8
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    mode_i,
    input  logic [msg_width_p-1:0]                  cmd_i,
    input  logic [addr_width_p-1:0]                 cmd_addr_i,
    input  logic                                    cmd_v_i,
    output logic                                    cmd_ready_and_o,
    output logic [msg_width_p-1:0]                  resp_o,
    output logic                                    resp_v_o,
    input  logic                                    resp_yumi_i,
    output logic [num_channels_p*msg_width_p-1:0]   ch_cmd_o,
    output logic [num_channels_p-1:0]               ch_cmd_v_o,
    input  logic [num_channels_p-1:0]               ch_cmd_ready_and_i,
    input  logic [num_channels_p*msg_width_p-1:0]   ch_resp_i,
    input  logic [num_channels_p-1:0]               ch_resp_v_i,
    output logic [num_channels_p-1:0]               ch_resp_yumi_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]  outstanding_o,
    output logic                                    mode_o,
    output logic                                    unexpected_resp_o
);

    localparam int LG_CH  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
    // Channel vectors are padded to 2**LG_CH entries so that indexing with an
    // LG_CH-bit channel ID is always in range, including the 1-channel case.
    localparam int CH_PAD = 1 << LG_CH;
    localparam int PTR_W  = $clog2(max_outstanding_p);
    localparam int CNT_W  = $clog2(max_outstanding_p + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LG_CH-1:0] fifo_q [max_outstanding_p];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             mode_q, mode_d;
    logic             err_q,  err_d;

    // ------------------------------------------------------------------------
    // Padded per-channel views
    // ------------------------------------------------------------------------
    logic [CH_PAD-1:0]      ready_pad;
    logic [CH_PAD-1:0]      resp_v_pad;
    logic [msg_width_p-1:0] resp_arr [CH_PAD];

    generate
        for (genvar g = 0; g < CH_PAD; g++) begin : g_pad
            if (g < num_channels_p) begin : g_real
                assign ready_pad[g]  = ch_cmd_ready_and_i[g];
                assign resp_v_pad[g] = ch_resp_v_i[g];
                assign resp_arr[g]   = ch_resp_i[g*msg_width_p +: msg_width_p];
            end else begin : g_fill
                assign ready_pad[g]  = 1'b0;
                assign resp_v_pad[g] = 1'b0;
                assign resp_arr[g]   = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Channel select (uses the latched mode, never the live request)
    // ------------------------------------------------------------------------
    logic [LG_CH-1:0] ch_sel;

    always_comb begin
        ch_sel = '0;
        if (num_channels_p > 1) begin
            if (mode_q) begin
                ch_sel = cmd_addr_i[stripe_lg_p +: LG_CH];
            end else begin
                ch_sel = cmd_addr_i[addr_width_p-1 -: LG_CH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command / response handshakes
    // ------------------------------------------------------------------------
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [LG_CH-1:0] head;

    // full comes from the registered count only, so a pop cannot open a slot
    // in the same cycle and resp_yumi_i never reaches cmd_ready_and_o.
    assign full  = (cnt_q == CNT_W'(max_outstanding_p));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

    assign cmd_ready_and_o = ready_pad[ch_sel] & ~full;
    assign push            = cmd_v_i & cmd_ready_and_o;

    assign resp_v_o = ~empty & resp_v_pad[head];
    assign resp_o   = resp_arr[head];
    assign pop      = resp_yumi_i & ~empty;

    generate
        for (genvar g = 0; g < num_channels_p; g++) begin : g_ch
            assign ch_cmd_o[g*msg_width_p +: msg_width_p] = cmd_i;
            assign ch_cmd_v_o[g]     = cmd_v_i & ~full & (ch_sel == LG_CH'(g));
            // Only the head channel is ever consumed; responses on other
            // channels wait until their command reaches the head.
            assign ch_resp_yumi_o[g] = pop & (head == LG_CH'(g));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        err_d  = err_q;

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Remap only when nothing is in flight, so no command is ever routed
        // under one mapping and answered under another.
        if (empty && !push) begin
            mode_d = mode_i;
        end

        if (empty && (|ch_resp_v_i)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            err_q  <= err_d;
        end
    end

    // Order storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= ch_sel;
        end
    end

    assign outstanding_o     = cnt_q;
    assign mode_o            = mode_q;
    assign unexpected_resp_o = err_q;

endmodule : bsg_blackparrot_mem_channel_striper
`default_nettype wire

// File: tb/tb_bsg_blackparrot_mem_channel_striper.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_blackparrot_mem_channel_striper
// Purpose  : Directed self-checking bench for the memory channel striper.
//            Main instance: 4 channels, 8-deep order FIFO. A second 2-channel
//            instance checks region routing with a 1-bit channel ID.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_blackparrot_mem_channel_striper;

    localparam int NCH  = 4;
    localparam int AW   = 40;
    localparam int MW   = 128;
    localparam int MAXO = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            mode;
    logic [MW-1:0]   cmd;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_v;
    logic            cmd_ready;
    logic [MW-1:0]   resp;
    logic            resp_v;
    logic            resp_yumi;
    logic [NCH*MW-1:0] ch_cmd;
    logic [NCH-1:0]  ch_cmd_v;
    logic [NCH-1:0]  ch_cmd_ready;
    logic [NCH*MW-1:0] ch_resp;
    logic [NCH-1:0]  ch_resp_v;
    logic [NCH-1:0]  ch_resp_yumi;
    logic [3:0]      outstanding;
    logic            mode_out;
    logic            unexpected;

    // 2-channel instance
    logic            d2_cmd_v;
    logic            d2_cmd_ready;
    logic [MW-1:0]   d2_resp;
    logic            d2_resp_v;
    logic [2*MW-1:0] d2_ch_cmd;
    logic [1:0]      d2_ch_cmd_v;
    logic [1:0]      d2_ch_resp_yumi;
    logic [3:0]      d2_outstanding;
    logic            d2_mode_out;
    logic            d2_unexpected;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bsg_blackparrot_mem_channel_striper #(
        .num_channels_p   (NCH),
        .addr_width_p     (AW),
        .msg_width_p      (MW),
        .stripe_lg_p      (6),
        .max_outstanding_p(MAXO)
    ) u_dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .mode_i            (mode),
        .cmd_i             (cmd),
        .cmd_addr_i        (cmd_addr),
        .cmd_v_i           (cmd_v),
        .cmd_ready_and_o   (cmd_ready),
        .resp_o            (resp),
        .resp_v_o          (resp_v),
        .resp_yumi_i       (resp_yumi),
        .ch_cmd_o          (ch_cmd),
        .ch_cmd_v_o        (ch_cmd_v),
        .ch_cmd_ready_and_i(ch_cmd_ready),
        .ch_resp_i         (ch_resp),
        .ch_resp_v_i       (ch_resp_v),
        .ch_resp_yumi_o    (ch_resp_yumi),
        .outstanding_o     (outstanding),
        .mode_o            (mode_out),
        .unexpected_resp_o (unexpected)
    );

    bsg_blackparrot_mem_channel_striper #(
        .num_channels_p   (2),
        .addr_width_p     (AW),
        .msg_width_p      (MW),
        .stripe_lg_p      (6),
        .max_outstanding_p(MAXO)
    ) u_dut2 (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .mode_i            (1'b0),
        .cmd_i             (cmd),
        .cmd_addr_i        (cmd_addr),
        .cmd_v_i           (d2_cmd_v),
        .cmd_ready_and_o   (d2_cmd_ready),
        .resp_o            (d2_resp),
        .resp_v_o          (d2_resp_v),
        .resp_yumi_i       (1'b0),
        .ch_cmd_o          (d2_ch_cmd),
        .ch_cmd_v_o        (d2_ch_cmd_v),
        .ch_cmd_ready_and_i(2'b11),
        .ch_resp_i         ({2*MW{1'b0}}),
        .ch_resp_v_i       (2'b00),
        .ch_resp_yumi_o    (d2_ch_resp_yumi),
        .outstanding_o     (d2_outstanding),
        .mode_o            (d2_mode_out),
        .unexpected_resp_o (d2_unexpected)
    );

    task automatic check(input string tag, input logic [MW-1:0] got,
                         input logic [MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // after a further settle delay, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] resp_pat(input int c);
        return MW'(32'hBEEF_0000 + c);
    endfunction

    // Present one command, check its routing, and complete the handshake.
    task automatic issue(input string tag, input logic [AW-1:0] addr,
                         input int exp_ch);
        logic [NCH-1:0] oh;
        oh       = NCH'(1) << exp_ch;
        cmd_addr = addr;
        cmd      = {88'h00C0_FFEE, addr};
        cmd_v    = 1'b1;
        #1;
        check({tag, "_route"}, MW'(ch_cmd_v), MW'(oh));
        check({tag, "_ready"}, MW'(cmd_ready), MW'(1));
        check({tag, "_data"}, ch_cmd[exp_ch*MW +: MW], cmd);
        tick();
        cmd_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        mode         = 1'b0;
        cmd          = '0;
        cmd_addr     = '0;
        cmd_v        = 1'b0;
        resp_yumi    = 1'b0;
        ch_cmd_ready = '1;
        ch_resp_v    = '0;
        d2_cmd_v     = 1'b0;
        for (int c = 0; c < NCH; c++) ch_resp[c*MW +: MW] = resp_pat(c);

        tick();
        tick();
        check("rst_outstanding", MW'(outstanding), 0);
        check("rst_resp_v", MW'(resp_v), 0);
        check("rst_ch_cmd_v", MW'(ch_cmd_v), 0);
        check("rst_yumi", MW'(ch_resp_yumi), 0);
        check("rst_mode", MW'(mode_out), 0);
        check("rst_unexpected", MW'(unexpected), 0);
        reset_n = 1'b1;

        // ---- Striped fan-out ----
        mode = 1'b1;
        tick();
        check("mode_latched_idle", MW'(mode_out), 1);
        issue("stripe0", 40'h000, 0);
        issue("stripe1", 40'h040, 1);
        issue("stripe2", 40'h080, 2);
        issue("stripe3", 40'h0C0, 3);
        issue("stripe4", 40'h100, 0);
        check("stripe_outstanding", MW'(outstanding), 5);

        // Drain in order: 0,1,2,3,0 with every channel valid.
        ch_resp_v = '1;
        resp_yumi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int c;
            c = i % 4;
            #1;
            check("drain_resp", resp, resp_pat(c));
            check("drain_yumi", MW'(ch_resp_yumi), MW'(NCH'(1) << c));
            tick();
        end
        ch_resp_v = '0;
        resp_yumi = 1'b0;
        #1;
        check("drain_outstanding", MW'(outstanding), 0);
        check("drain_no_unexpected", MW'(unexpected), 0);

        // ---- Reordering: ch2 answers before ch0 ----
        issue("reord_a", 40'h000, 0);
        issue("reord_b", 40'h080, 2);
        ch_resp_v = 4'b0100;
        #1;
        check("reord_hold_v", MW'(resp_v), 0);
        check("reord_hold_yumi", MW'(ch_resp_yumi), 0);
        tick();
        check("reord_hold_v2", MW'(resp_v), 0);
        ch_resp_v = 4'b0101;
        resp_yumi = 1'b1;
        #1;
        check("reord_first_v", MW'(resp_v), 1);
        check("reord_first_data", resp, resp_pat(0));
        check("reord_first_yumi", MW'(ch_resp_yumi), MW'(4'b0001));
        tick();
        check("reord_second_data", resp, resp_pat(2));
        check("reord_second_yumi", MW'(ch_resp_yumi), MW'(4'b0100));
        tick();
        resp_yumi = 1'b0;
        ch_resp_v = '0;
        #1;
        check("reord_outstanding", MW'(outstanding), 0);

        // ---- Full ----
        for (int i = 0; i < MAXO; i++) issue("fill", AW'(i * 64), i % 4);
        cmd_addr = 40'h200;
        cmd_v    = 1'b1;
        #1;
        check("full_outstanding", MW'(outstanding), MAXO);
        check("full_ready", MW'(cmd_ready), 0);
        check("full_ch_cmd_v", MW'(ch_cmd_v), 0);
        ch_resp_v = 4'b0001;
        resp_yumi = 1'b1;
        #1;
        check("full_same_cycle_ready", MW'(cmd_ready), 0);
        tick();
        resp_yumi = 1'b0;
        ch_resp_v = '0;
        #1;
        check("full_after_pop_cnt", MW'(outstanding), MAXO - 1);
        check("full_after_pop_ready", MW'(cmd_ready), 1);
        check("full_after_pop_route", MW'(ch_cmd_v), MW'(4'b0001));
        tick();
        cmd_v = 1'b0;
        #1;
        check("full_refill_cnt", MW'(outstanding), MAXO);
        ch_resp_v = '1;
        resp_yumi = 1'b1;
        for (int i = 0; i < MAXO; i++) tick();
        ch_resp_v = '0;
        resp_yumi = 1'b0;
        #1;
        check("full_drained", MW'(outstanding), 0);

        // ---- Mode change held while busy; region routing ----
        mode = 1'b0;
        tick();
        check("mode_back_to_region", MW'(mode_out), 0);
        issue("region0", 40'h00_0000_0000, 0);
        issue("region1", 40'h40_0000_0000, 1);
        cmd_addr = 40'h80_0000_0000;
        d2_cmd_v = 1'b1;
        #1;
        check("region_2ch_route", MW'(d2_ch_cmd_v), MW'(2'b10));
        d2_cmd_v = 1'b0;
        issue("region2", 40'h80_0000_0000, 2);
        mode = 1'b1;
        tick();
        check("mode_held_busy", MW'(mode_out), 0);
        ch_resp_v = 4'b0111;
        resp_yumi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mode_held_drain", MW'(mode_out), 0);
        end
        ch_resp_v = '0;
        resp_yumi = 1'b0;
        tick();
        check("mode_switched", MW'(mode_out), 1);

        // ---- Reset mid-flight, then a spurious response ----
        issue("rst_a", 40'h000, 0);
        issue("rst_b", 40'h040, 1);
        issue("rst_c", 40'h080, 2);
        issue("rst_d", 40'h0C0, 3);
        check("rst_pre_outstanding", MW'(outstanding), 4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_mid_outstanding", MW'(outstanding), 0);
        check("rst_mid_mode", MW'(mode_out), 0);
        ch_resp_v = 4'b0010;
        #1;
        check("spurious_resp_v", MW'(resp_v), 0);
        check("spurious_yumi", MW'(ch_resp_yumi), 0);
        check("spurious_flag_pre", MW'(unexpected), 0);
        tick();
        check("spurious_flag_set", MW'(unexpected), 1);
        ch_resp_v = '0;
        tick();
        check("spurious_flag_held", MW'(unexpected), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bsg_blackparrot_mem_channel_striper
`default_nettype wire

// File: doc/bsg_blackparrot_mem_channel_striper.md
# bsg_blackparrot_mem_channel_striper

Parametrised memory-channel distributor placed between the BlackParrot unicore memory command/response port and N DRAM-side CCE-to-manycore bridges. It generalises the fixed two-way DRAM split to `num_channels_p` channels, with runtime-selectable region or striped address interleaving. It tracks outstanding commands in an in-order channel-ID FIFO, so responses return to the core in command order regardless of per-channel latency.

## Interface
- `num_channels_p`, 2: downstream channel count; power of two, 1..8; `lg_ch = max(1, clog2(num_channels_p))`.
- `addr_width_p`, 40: physical address width.
- `msg_width_p`, 128: opaque command/response message width (header plus payload), passed through unmodified.
- `stripe_lg_p`, 6: log2 of the stripe granule in bytes (64 B is one cache block).
- `max_outstanding_p`, 8: order FIFO depth; power of two, at least 2.
- `clk_i` input 1: core clock.
- `reset_n_i` input 1: reset, synchronous and active-low.
- `mode_i` input 1: 0 selects region mode, 1 selects striped mode; the value is latched only when the block is idle.
- `cmd_i` input `msg_width_p`: command from the core.
- `cmd_addr_i` input `addr_width_p`: address field of `cmd_i`.
- `cmd_v_i` input 1: command valid.
- `cmd_ready_and_o` output 1: command ready (ready/valid handshake).
- `resp_o` output `msg_width_p`: response to the core.
- `resp_v_o` output 1: response valid.
- `resp_yumi_i` input 1: core consumes the response.
- `ch_cmd_o` output `num_channels_p`×`msg_width_p`: per-channel command; the same `cmd_i` is broadcast to every channel.
- `ch_cmd_v_o` output `num_channels_p`: per-channel command valid; one-hot or zero.
- `ch_cmd_ready_and_i` input `num_channels_p`: per-channel command ready.
- `ch_resp_i` input `num_channels_p`×`msg_width_p`: per-channel response.
- `ch_resp_v_i` input `num_channels_p`: per-channel response valid.
- `ch_resp_yumi_o` output `num_channels_p`: per-channel response consume; one-hot or zero.
- `outstanding_o` output `clog2(max_outstanding_p+1)`: number of commands issued whose responses have not yet been returned.
- `mode_o` output 1: currently latched mode.
- `unexpected_resp_o` output 1: sticky error flag.

## Operation
**Channel select**
- Computed from `mode_r`, the latched mode.
- Region mode (`mode_r`=0): `ch = cmd_addr_i[addr_width_p-1 -: lg_ch]`.
- Striped mode (`mode_r`=1): `ch = cmd_addr_i[stripe_lg_p +: lg_ch]`.
- When `num_channels_p`=1, `ch` is always 0.

**Command path**
- `full = (outstanding == max_outstanding_p)`.
- `ch_cmd_v_o[ch] = cmd_v_i & ~full`; all other `ch_cmd_v_o` bits are 0.
- `cmd_ready_and_o = ch_cmd_ready_and_i[ch] & ~full`.
- On a command handshake (`cmd_v_i & cmd_ready_and_o`), `ch` is pushed into the order FIFO.

**Response path**
- Let `head` be the FIFO head channel.
- `resp_v_o = ~empty & ch_resp_v_i[head]`.
- `resp_o = ch_resp_i[head]`.
- `ch_resp_yumi_o[head] = resp_yumi_i`; all other yumi bits are 0.
- A response becoming valid on a non-head channel is held: it is not consumed until that channel reaches the head.
- `resp_yumi_i` pops the FIFO.

**Counter**
- `outstanding` increments on a push and decrements on a pop.
- A simultaneous push and pop leaves it unchanged.
- Push when full is impossible, because `full` gates the command ready.
- `full` depends on registered state only, so a pop in the same cycle does not free a slot until the next cycle.

**Mode latch**
- `mode_r <= mode_i` on any cycle with `outstanding==0` and no command handshake.
- `mode_r` is otherwise held. This prevents address remapping while commands are in flight.

**Error flag**
- `unexpected_resp_o` is set when any `ch_resp_v_i` bit is 1 while the FIFO is empty.
- It is cleared only by reset.

**Pointers**
- Read and write pointers are `clog2(max_outstanding_p)` bits wide and wrap naturally from `max_outstanding_p-1` to 0.

## Timing
**Reset**
- While `reset_n_i`=0 at a rising edge: the FIFO empties, `outstanding` becomes 0, `mode_r` becomes 0 and `unexpected_resp_o` becomes 0.
- During and after reset, all `ch_cmd_v_o`, `ch_resp_yumi_o` and `resp_v_o` are 0 until stimulus arrives, and `outstanding_o`=0.
- A reset asserted mid-operation drops all tracking. Responses still in flight afterwards assert `unexpected_resp_o`.

**Latency**
- Command path: 0 cycles, combinational from `cmd_v_i`/`cmd_addr_i` to `ch_cmd_v_o`.
- Response path: 0 cycles, combinational from `ch_resp_v_i[head]` to `resp_v_o`.
- `outstanding_o` updates on the clock edge after a handshake.
- A new `mode_i` value is visible on `mode_o` one cycle after the first idle edge.
- No combinational path exists from `resp_yumi_i` to `cmd_ready_and_o`.

## Test plan
1. **Striped fan-out.** `num_channels_p`=4, `mode_i`=1; issue addresses 0x000, 0x040, 0x080, 0x0C0, 0x100 with all readies high. Required: `ch_cmd_v_o` one-hot on channels 0, 1, 2, 3, 0 in turn, and `outstanding_o` reads 5.
2. **Reordering.** Channel 2 responds before channel 0 for commands issued as channel 0 then channel 2. Required: `resp_v_o`=0 until channel 0 is valid; the channel 0 response returns first; `ch_resp_yumi_o`=0b0001, then 0b0100.
3. **Full.** `max_outstanding_p`=8; issue 8 commands with no responses. Required: the 9th command sees `cmd_ready_and_o`=0. After one yumi, it is accepted on the following cycle, not the same cycle.
4. **Mode change.** Toggle `mode_i` 0→1 with 3 commands outstanding. Required: `mode_o` stays 0 until all 3 responses are returned, then reads 1 one cycle later. In region mode, address 0x80_0000_0000 with `lg_ch`=1 routes to channel 1.
5. **Reset mid-flight and spurious response.** Pulse `reset_n_i` low with 4 commands outstanding, then drive `ch_resp_v_i[1]`=1. Required: `outstanding_o`=0, `resp_v_o`=0, and `unexpected_resp_o`=1 on the next edge and held.
